// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Bundle of the encoder's field-input handshake and imem-write
//                signals. The encoder uses the slave modport and the field
//                source / imem side uses the master modport.
//  Signals     : clear_in, in_valid/in_ready, opcode/rd/rs1/rs2/funct3/
//                funct7/imm fields, imem_we/ready/addr/data, count, illegal
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
  parameter int ADDR_W = 5
);
  logic              clear_in;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode_in;
  logic [4:0]        rd_sel_in;
  logic [4:0]        rs1_sel_in;
  logic [4:0]        rs2_sel_in;
  logic [2:0]        funct3_in;
  logic [6:0]        funct7_in;
  logic [19:0]       imm_value_in;
  logic              imem_we_out;
  logic              imem_ready_in;
  logic [ADDR_W-1:0] imem_addr_out;
  logic [31:0]       imem_data_out;
  logic [ADDR_W:0]   count_out;
  logic              illegal_out;

  modport slave (
    input  clear_in, in_valid, opcode_in, rd_sel_in, rs1_sel_in, rs2_sel_in,
           funct3_in, funct7_in, imm_value_in, imem_ready_in,
    output in_ready, imem_we_out, imem_addr_out, imem_data_out, count_out,
           illegal_out
  );

  modport master (
    output clear_in, in_valid, opcode_in, rd_sel_in, rs1_sel_in, rs2_sel_in,
           funct3_in, funct7_in, imm_value_in, imem_ready_in,
    input  in_ready, imem_we_out, imem_addr_out, imem_data_out, count_out,
           illegal_out
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs decoded RV32I fields (R/I/S/B/U/J formats) into a
//                32-bit instruction word and writes it to instruction memory
//                at an auto-incrementing, wrapping word address. Bundles with
//                an unsupported opcode are consumed without producing a word
//                and raise a sticky illegal flag.
//  Ports       : clk    - clock, all state on rising edge
//                rst_n  - synchronous active-low reset
//                bus    - instr_encoder_if.slave: field input handshake,
//                         clear, imem write port, word count, illegal flag
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  logic              we_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              illegal_q;

  logic [31:0]       word;
  logic              legal;
  logic              accept;
  logic              retire;

  logic [19:0] b;
  assign b = bus.imm_value_in;

  // Format-specific packing; anything not listed is an unsupported opcode.
  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (bus.opcode_in)
      OP_R:
        word = {bus.funct7_in, bus.rs2_sel_in, bus.rs1_sel_in, bus.funct3_in,
                bus.rd_sel_in, bus.opcode_in};
      OP_IMM, OP_LOAD, OP_JALR:
        word = {b[11:0], bus.rs1_sel_in, bus.funct3_in, bus.rd_sel_in,
                bus.opcode_in};
      OP_STORE:
        word = {b[11:5], bus.rs2_sel_in, bus.rs1_sel_in, bus.funct3_in,
                b[4:0], bus.opcode_in};
      // b[11:0] carries offset[12:1]
      OP_BRANCH:
        word = {b[11], b[9:4], bus.rs2_sel_in, bus.rs1_sel_in, bus.funct3_in,
                b[3:0], b[10], bus.opcode_in};
      OP_LUI, OP_AUIPC:
        word = {b[19:0], bus.rd_sel_in, bus.opcode_in};
      // b[19:0] carries offset[20:1]
      OP_JAL:
        word = {b[19], b[9:0], b[10], b[18:11], bus.rd_sel_in, bus.opcode_in};
      default: legal = 1'b0;
    endcase
  end

  // One output register: a new bundle may enter in the same cycle the
  // pending word retires, giving one word per cycle with no bubble.
  assign bus.in_ready = !we_q || bus.imem_ready_in;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = we_q && bus.imem_ready_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      data_q    <= 32'd0;
      addr_q    <= BASE;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      // Clear resets bookkeeping only; a pending word stays and is written
      // at BASE.
      if (bus.clear_in) begin
        addr_q    <= BASE;
        count_q   <= '0;
        illegal_q <= 1'b0;
      end else begin
        if (retire) begin
          addr_q <= addr_q + ONE;
          if (count_q != '1) begin
            count_q <= count_q + CNT_ONE;
          end
        end
        if (accept && !legal) begin
          illegal_q <= 1'b1;
        end
      end

      if (accept && legal) begin
        we_q   <= 1'b1;
        data_q <= word;
      end else if (retire) begin
        we_q <= 1'b0;
      end
    end
  end

  assign bus.imem_we_out   = we_q;
  assign bus.imem_data_out = data_q;
  assign bus.imem_addr_out = addr_q;
  assign bus.count_out     = count_q;
  assign bus.illegal_out   = illegal_q;

endmodule
`default_nettype wire
